// File: rtl/mips_mc_controller.sv
// mips_mc_controller -- multicycle MIPS control unit (Moore FSM).
//
// Purpose: sequences the shared-memory multicycle datapath through
// fetch/decode/execute/writeback. Memory accesses use a ready handshake.
// A wait counter turns a stalled memory into a sticky fault state.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   op, funct  in   opcode / R-type function field from the IR
//   zero       in   ALU zero flag (current cycle)
//   mem_ready  in   memory handshake (read data valid / write accepted)
//   iord, memwrite, irwrite, regdst, memtoreg, regwrite, pcen  out  strobes/selects
//   alusrca, alusrcb, pcsrc  out  2-bit mux selects
//   alucontrol out   3-bit ALU operation
//   err        out   sticky fault flag (high while in ERR)
//   state      out   current state encoding (debug)
//
// Optional feature: define MC_BNE_EN to decode BNE (op 000101) into the
// BRANCH state with pcen = ~zero. Without it, op 000101 faults.

module mips_mc_controller #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       pcen,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_LUIEX    = 4'd12,
    S_ERR      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // Last count value before the TIMEOUT-th consecutive wait cycle.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;

  logic funct_legal;
  logic bne_op;
  logic branch_taken;

  // ALU operation for an R-type instruction; illegal functs never reach
  // EXECUTE, so the fallback value is irrelevant.
  function automatic logic [2:0] funct_to_alu(input logic [5:0] f);
    logic [2:0] a;
    a = 3'b010;
    case (f)
      6'b100000: a = 3'b010;
      6'b100010: a = 3'b110;
      6'b100100: a = 3'b000;
      6'b100101: a = 3'b001;
      6'b101010: a = 3'b111;
      6'b000100: a = 3'b100;
      default:   a = 3'b010;
    endcase
    return a;
  endfunction

  assign funct_legal = (funct == 6'b100000) || (funct == 6'b100010) ||
                       (funct == 6'b100100) || (funct == 6'b100101) ||
                       (funct == 6'b101010) || (funct == 6'b000100);

`ifdef MC_BNE_EN
  assign bne_op       = (op == OP_BNE);
  assign branch_taken = bne_op ? ~zero : zero;
`else
  assign bne_op       = 1'b0;
  assign branch_taken = zero;
`endif

  // Next-state logic. Wait states share one timeout rule: a ready exits,
  // otherwise the counter advances and faults on its TIMEOUT-th zero.
  always_comb begin
    state_d = state_q;
    wait_d  = 8'd0;
    case (state_q)
      S_FETCH, S_MEMREAD, S_MEMWRITE: begin
        if (mem_ready) begin
          case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_MEMREAD: state_d = S_MEMWB;
            default:   state_d = S_FETCH;
          endcase
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        if ((op == OP_LW) || (op == OP_SW))    state_d = S_MEMADR;
        else if (op == OP_RTYPE)               state_d = funct_legal ? S_EXECUTE : S_ERR;
        else if ((op == OP_BEQ) || bne_op)     state_d = S_BRANCH;
        else if (op == OP_ADDI)                state_d = S_ADDIEX;
        else if (op == OP_J)                   state_d = S_JUMP;
        else if (op == OP_LUI)                 state_d = S_LUIEX;
        else                                   state_d = S_ERR;
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMREAD;
        else if (op == OP_SW) state_d = S_MEMWRITE;
        else                  state_d = S_ERR;
      end
      S_MEMWB:   state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_LUIEX:   state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_ERR:     state_d = S_ERR;
      default:   state_d = S_ERR;   // unused encodings 14/15
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Output decode. Write/enable strobes are gated by reset so nothing is
  // committed while reset is held, even though FETCH follows mem_ready.
  always_comb begin
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    pcen       = 1'b0;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b010;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready & reset;
        pcen    = mem_ready & reset;
      end
      S_DECODE:   alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
      end
      S_MEMREAD:  iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = reset;
      end
      S_MEMWRITE: begin
        iord     = 1'b1;
        memwrite = reset;
      end
      S_EXECUTE: begin
        alusrca    = 2'b01;
        alucontrol = funct_to_alu(funct);
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = reset;
      end
      S_BRANCH: begin
        alusrca    = 2'b01;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        pcen       = branch_taken & reset;
      end
      S_ADDIEX: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
      end
      S_ADDIWB:   regwrite = reset;
      S_LUIEX: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b10;
        alucontrol = 3'b100;
      end
      S_JUMP: begin
        pcsrc = 2'b10;
        pcen  = reset;
      end
      default: ;
    endcase
  end

  assign err   = (state_q == S_ERR);
  assign state = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller -- bench for mips_mc_controller.
// An instruction-level reference model (per-instruction state paths plus a
// wait counter) predicts every output each cycle; directed sequences pin
// the model with hand-written state traces and output values.

module tb_mips_mc_controller;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, pcen;
  logic [1:0] alusrca, alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       err;
  logic [3:0] state;

  mips_mc_controller #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .pcen(pcen), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .err(err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       err, iord, memwrite, irwrite, regdst, memtoreg, regwrite, pcen;
    logic [1:0] asa, asb, pcs;
    logic [2:0] alu;
  } obs_t;

  obs_t obs;
  assign obs = {state, err, iord, memwrite, irwrite, regdst, memtoreg,
                regwrite, pcen, alusrca, alusrcb, pcsrc, alucontrol};

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_state = 0;
  int m_wait  = 0;
  int m_path[$];

  // States an instruction visits after DECODE; empty means fault.
  task automatic build_path(input logic [5:0] o, input logic [5:0] f);
    m_path.delete();
    if (o == 6'b100011) m_path = '{2, 3, 4};
    else if (o == 6'b101011) m_path = '{2, 5};
    else if (o == 6'b000000) begin
      if (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
          f == 6'b100101 || f == 6'b101010 || f == 6'b000100)
        m_path = '{6, 7};
    end
    else if (o == 6'b000100) m_path = '{8};
`ifdef MC_BNE_EN
    else if (o == 6'b000101) m_path = '{8};
`endif
    else if (o == 6'b001000) m_path = '{9, 10};
    else if (o == 6'b000010) m_path = '{11};
    else if (o == 6'b001111) m_path = '{12, 10};
  endtask

  function automatic int pop_or_fetch();
    if (m_path.size() == 0) return 0;
    return m_path.pop_front();
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_state = 0;
        m_wait  = 0;
        m_path.delete();
      end else if (m_state == 13) begin
        m_state = 13;
      end else if (m_state == 0 || m_state == 3 || m_state == 5) begin
        if (mem_ready) begin
          m_wait  = 0;
          m_state = (m_state == 0) ? 1 : pop_or_fetch();
        end else begin
          m_wait++;
          if (m_wait == TO) begin
            m_state = 13;
            m_wait  = 0;
          end
        end
      end else if (m_state == 1) begin
        build_path(op, funct);
        m_state = (m_path.size() == 0) ? 13 : m_path.pop_front();
      end else begin
        m_state = pop_or_fetch();
      end
    end
  end

  function automatic logic [2:0] r_alu(input logic [5:0] f);
    if (f == 6'b100010) return 3'b110;
    if (f == 6'b100100) return 3'b000;
    if (f == 6'b100101) return 3'b001;
    if (f == 6'b101010) return 3'b111;
    if (f == 6'b000100) return 3'b100;
    return 3'b010;
  endfunction

  function automatic obs_t model_out(input int st, input logic [5:0] o,
                                     input logic [5:0] f, input logic z,
                                     input logic mr, input logic rn);
    obs_t e;
    logic taken;
`ifdef MC_BNE_EN
    taken = (o == 6'b000101) ? !z : z;
`else
    taken = z;
`endif
    e          = '0;
    e.st       = 4'(st);
    e.err      = (st == 13);
    e.iord     = (st == 3 || st == 5);
    e.memwrite = rn && st == 5;
    e.irwrite  = rn && st == 0 && mr;
    e.regdst   = (st == 7);
    e.memtoreg = (st == 4);
    e.regwrite = rn && (st == 4 || st == 7 || st == 10);
    e.pcen     = rn && ((st == 0 && mr) || st == 11 || (st == 8 && taken));
    e.asa      = (st == 2 || st == 6 || st == 8 || st == 9) ? 2'b01 :
                 (st == 12) ? 2'b10 : 2'b00;
    e.asb      = (st == 0) ? 2'b01 : (st == 1) ? 2'b11 :
                 (st == 2 || st == 9 || st == 12) ? 2'b10 : 2'b00;
    e.pcs      = (st == 8) ? 2'b01 : (st == 11) ? 2'b10 : 2'b00;
    e.alu      = (st == 6) ? r_alu(f) : (st == 8) ? 3'b110 :
                 (st == 12) ? 3'b100 : 3'b010;
    return e;
  endfunction

  // Every-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        obs_t e;
        e = model_out(m_state, op, funct, zero, mem_ready, reset);
        n_vec++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL model_cmp t=%0t st=%0d got=%h want=%h", $time, m_state, obs, e);
        end
      end
    end
  end

  // ---------------- directed sequences ----------------
  int   exp_q[$];
  bit   mr_q[$];
  bit   z_q[$];
  obs_t snaps[$];

  task automatic do_reset();
    reset     = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_strobes", int'({pcen, irwrite, memwrite, regwrite}), 0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic run_seq(input string nm);
    snaps.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_ready = mr_q[i];
      zero      = z_q[i];
      @(negedge clk);
      snaps.push_back(obs);
      chk({nm, "_state"}, int'(obs.st), exp_q[i]);
      @(posedge clk); #1;
    end
  endtask

  task automatic fill(input int n, input bit mr, input bit z);
    mr_q.delete();
    z_q.delete();
    for (int i = 0; i < n; i++) begin
      mr_q.push_back(mr);
      z_q.push_back(z);
    end
  endtask

  logic [5:0] op_tab [8];
  logic [5:0] fn_tab [6];

  initial begin
    op_tab = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
               6'b001000, 6'b000010, 6'b001111, 6'b000101};
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
               6'b101010, 6'b000100};
    reset = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;

    // add
    do_reset();
    op = 6'b000000; funct = 6'b100000;
    exp_q = '{0, 1, 6, 7, 0}; fill(5, 1'b1, 1'b0);
    run_seq("add");
    chk("add_regwrite_aluwb", int'(snaps[3].regwrite), 1);
    chk("add_regwrite_exec", int'(snaps[2].regwrite), 0);
    chk("add_regdst", int'(snaps[3].regdst), 1);
    chk("add_alu", int'(snaps[2].alu), 2);

    // lw with three wait cycles in MEMREAD
    do_reset();
    op = 6'b100011;
    exp_q = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    fill(9, 1'b1, 1'b0);
    mr_q[3] = 1'b0; mr_q[4] = 1'b0; mr_q[5] = 1'b0;
    run_seq("lw");
    for (int i = 3; i <= 6; i++) chk("lw_iord", int'(snaps[i].iord), 1);
    chk("lw_memtoreg", int'(snaps[7].memtoreg), 1);
    chk("lw_regwrite", int'(snaps[7].regwrite), 1);

    // sw with one wait cycle
    do_reset();
    op = 6'b101011;
    exp_q = '{0, 1, 2, 5, 5, 0}; fill(6, 1'b1, 1'b0); mr_q[3] = 1'b0;
    run_seq("sw");
    chk("sw_memwrite0", int'(snaps[3].memwrite), 1);
    chk("sw_memwrite1", int'(snaps[4].memwrite), 1);

    // beq taken / not taken
    do_reset();
    op = 6'b000100;
    exp_q = '{0, 1, 8, 0}; fill(4, 1'b1, 1'b1);
    run_seq("beq_t");
    chk("beq_t_pcen", int'(snaps[2].pcen), 1);
    chk("beq_t_pcsrc", int'(snaps[2].pcs), 1);
    do_reset();
    exp_q = '{0, 1, 8, 0}; fill(4, 1'b1, 1'b0);
    run_seq("beq_n");
    chk("beq_n_pcen", int'(snaps[2].pcen), 0);
    chk("beq_n_pcsrc", int'(snaps[2].pcs), 1);

    // lui
    do_reset();
    op = 6'b001111;
    exp_q = '{0, 1, 12, 10, 0}; fill(5, 1'b1, 1'b0);
    run_seq("lui");
    chk("lui_alu", int'(snaps[2].alu), 4);
    chk("lui_asa", int'(snaps[2].asa), 2);

    // jump
    do_reset();
    op = 6'b000010;
    exp_q = '{0, 1, 11, 0}; fill(4, 1'b1, 1'b0);
    run_seq("j");
    chk("j_pcen", int'(snaps[2].pcen), 1);
    chk("j_pcsrc", int'(snaps[2].pcs), 2);

    // timeout in FETCH, then sticky err with ready high, then reset
    do_reset();
    exp_q.delete();
    for (int i = 0; i < TO; i++) exp_q.push_back(0);
    exp_q.push_back(13); exp_q.push_back(13);
    fill(TO + 2, 1'b0, 1'b0);
    mr_q[TO] = 1'b1; mr_q[TO + 1] = 1'b1;
    run_seq("tmo");
    chk("tmo_err_before", int'(snaps[TO - 1].err), 0);
    chk("tmo_err", int'(snaps[TO].err), 1);
    chk("tmo_err_sticky", int'(snaps[TO + 1].err), 1);
    do_reset();
    chk("tmo_after_rst", int'(state), 0);

    // bne
    do_reset();
    op = 6'b000101;
`ifdef MC_BNE_EN
    exp_q = '{0, 1, 8, 0}; fill(4, 1'b1, 1'b0);
    run_seq("bne");
    chk("bne_pcen", int'(snaps[2].pcen), 1);
`else
    exp_q = '{0, 1, 13, 13}; fill(4, 1'b1, 1'b0);
    run_seq("bne");
    chk("bne_err", int'(snaps[2].err), 1);
`endif

    // illegal op and illegal funct
    do_reset();
    op = 6'b111111;
    exp_q = '{0, 1, 13}; fill(3, 1'b1, 1'b0);
    run_seq("badop");
    do_reset();
    op = 6'b000000; funct = 6'b000000;
    exp_q = '{0, 1, 13}; fill(3, 1'b1, 1'b0);
    run_seq("badfn");

    // randomized phase against the model
    do_reset();
    begin
      int burst = 0;
      int rst_left = 0;
      for (int c = 0; c < 4000; c++) begin
        if (m_state == 0) begin
          int k;
          k  = $urandom_range(0, 9);
          op = (k < 8) ? op_tab[k] : 6'($urandom);
          funct = ($urandom_range(0, 4) != 0) ? fn_tab[$urandom_range(0, 5)]
                                               : 6'($urandom);
        end
        if (!reset) begin
          if (rst_left > 0) rst_left--;
          else reset = 1'b1;
        end else if ((m_state == 13 && $urandom_range(0, 3) == 0) ||
                     $urandom_range(0, 99) == 0) begin
          reset    = 1'b0;
          rst_left = $urandom_range(0, 1);
        end
        zero = 1'($urandom);
        if (burst > 0) begin
          mem_ready = 1'b0;
          burst--;
        end else if ($urandom_range(0, 49) == 0) begin
          burst     = $urandom_range(TO - 2, TO + 2);
          mem_ready = 1'b0;
        end else begin
          mem_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
      end
    end

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_mc_controller.md
MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
REQ-001 Parameter: TIMEOUT, default 16, max consecutive memory wait cycles before fault (legal range 2..255).
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-004 op  in  6  instruction opcode from instruction register.
REQ-005 funct  in  6  R-type function field.
REQ-006 zero  in  1  ALU zero flag, current cycle.
REQ-007 mem_ready  in  1  memory handshake; 1 = read data valid / write accepted this cycle.
REQ-008 iord, memwrite, irwrite, regdst, memtoreg, regwrite, pcen  out  1 each  standard multicycle datapath strobes/selects.
REQ-009 alusrca  out  2  00 PC, 01 A reg, 10 constant 16.
REQ-010 alusrcb  out  2  00 B reg, 01 constant 4, 10 signimm, 11 signimm<<2.
REQ-011 pcsrc  out  2  00 ALU result, 01 ALUOut reg, 10 jump target.
REQ-012 alucontrol  out  3  000 and, 001 or, 010 add, 100 sllv (srcb<<srca[4:0]), 110 sub, 111 slt.
REQ-013 err  out  1  sticky fault flag.
REQ-014 state  out  4  current state encoding, debug only.

Function
REQ-015 Moore FSM, states/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, LUIEX 12, ERR 13; 14-15 unreachable, SHALL go to ERR.
REQ-016 Unlisted outputs SHALL be 0 in every state; alucontrol defaults to 010.
REQ-017 FETCH: alusrca 00, alusrcb 01, add, pcsrc 00, iord 0; irwrite=pcen=mem_ready; holds until mem_ready=1, then DECODE.
REQ-018 DECODE: alusrca 00, alusrcb 11, add; next by op: 100011/101011 MEMADR, 000000 EXECUTE (if funct legal), 000100 BRANCH, 001000 ADDIEX, 000010 JUMP, 001111 LUIEX, else ERR.
REQ-019 Legal funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000100 sllv; any other funct with op 000000 SHALL go to ERR.
REQ-020 MEMADR: alusrca 01, alusrcb 10, add; lw to MEMREAD, sw to MEMWRITE.
REQ-021 MEMREAD: iord 1; holds until mem_ready=1, then MEMWB.
REQ-022 MEMWB: regdst 0, memtoreg 1, regwrite 1; then FETCH.
REQ-023 MEMWRITE: iord 1, memwrite 1 for every cycle in state; exits to FETCH the cycle mem_ready=1.
REQ-024 EXECUTE: alusrca 01, alusrcb 00, alucontrol per funct; then ALUWB (regdst 1, memtoreg 0, regwrite 1), then FETCH.
REQ-025 BRANCH: alusrca 01, alusrcb 00, sub, pcsrc 01, pcen=zero; then FETCH.
REQ-026 ADDIEX: alusrca 01, alusrcb 10, add; then ADDIWB (regdst 0, memtoreg 0, regwrite 1), then FETCH.
REQ-027 LUIEX: alusrca 10, alusrcb 10, alucontrol 100; then ADDIWB.
REQ-028 JUMP: pcsrc 10, pcen 1; then FETCH.
REQ-029 Wait counter: counts consecutive mem_ready=0 cycles in FETCH/MEMREAD/MEMWRITE; cleared on every state change; on the TIMEOUT-th consecutive 0, next state ERR.
REQ-030 ERR: all strobes 0, err 1, remains until reset; mem_ready ignored.
REQ-031 mem_ready=1 on first cycle of a wait state SHALL exit with zero added latency.

Reset
REQ-032 reset=0 SHALL asynchronously force state FETCH, wait counter 0, err 0.
REQ-033 While reset=0, pcen, irwrite, memwrite, regwrite SHALL be 0 regardless of mem_ready.
REQ-034 Reset asserted mid-instruction (any state incl. ERR) SHALL abandon it; first cycle after release is FETCH.

Configuration
REQ-035 Macro MC_BNE_EN: defined, op 000101 goes DECODE to BRANCH with pcen=~zero; undefined, op 000101 goes to ERR and BEQ behaviour is unchanged.

Verification
REQ-036 add (op 0, funct 100000), mem_ready=1 always -> states 0,1,6,7,0; regwrite=1 only in ALUWB; regdst=1.
REQ-037 lw with mem_ready low 3 cycles in MEMREAD -> state 3 held 4 cycles, iord=1 throughout, then MEMWB with memtoreg=1.
REQ-038 beq with zero=1 then zero=0 -> pcen=1 in BRANCH for first, 0 for second; pcsrc=01 both.
REQ-039 lui (op 001111) -> states 0,1,12,10,0; LUIEX alucontrol=100, alusrca=10.
REQ-040 TIMEOUT=16, mem_ready held 0 in FETCH -> ERR after 16 cycles, err=1 sticky; reset=0 -> FETCH, err=0.
REQ-041 op 000101: with MC_BNE_EN and zero=0 -> pcen=1; without macro -> ERR; op 111111 -> ERR.
